mcs4_rom_loader: RTL and testbench

Sequencer that owns the MCS4 system's ROM initialization port. On command it holds the i4004 CPU in reset, streams a byte image into program ROM through the ROM_INIT_* interface, and reads the image back to verify a 16-bit checksum. On a match it releases the CPU; on a mismatch it flags an error and keeps the CPU held. It sits between a host byte source (UART/JTAG bridge) and the MCS4_SYS ROM_INIT_* and RES_N inputs.

---
 rtl/mcs4_rom_loader_if.sv | 26 ++
 rtl/mcs4_rom_loader.sv | 205 ++++++++++++++++++++
 tb/tb_mcs4_rom_loader.sv | 233 +++++++++++++++++++++++
 3 files changed

// File: rtl/mcs4_rom_loader_if.sv
// Byte-stream and ROM-init bus between the loader, the host byte source and MCS4_SYS.
interface mcs4_rom_loader_if #(
    parameter int unsigned ADDR_W = 12
);
    logic [7:0]        s_data;
    logic              s_valid;
    logic              s_ready;
    logic              rom_init_enb;
    logic [ADDR_W-1:0] rom_init_addr;
    logic              rom_init_re;
    logic              rom_init_we;
    logic [7:0]        rom_init_wdata;
    logic [7:0]        rom_init_rdata;

    // Loader side: consumes the byte stream, drives the ROM init port.
    modport master (
        input  s_data, s_valid, rom_init_rdata,
        output s_ready, rom_init_enb, rom_init_addr, rom_init_re, rom_init_we, rom_init_wdata
    );

    // Host byte source and ROM side.
    modport slave (
        output s_data, s_valid, rom_init_rdata,
        input  s_ready, rom_init_enb, rom_init_addr, rom_init_re, rom_init_we, rom_init_wdata
    );
endinterface

// File: rtl/mcs4_rom_loader.sv
// Holds the i4004 in reset, streams an image into program ROM, reads it back,
// and releases the CPU only when the 16-bit read-back sum matches the written sum.
module mcs4_rom_loader #(
    parameter int unsigned ADDR_W  = 12,
    parameter int unsigned REL_DLY = 4
) (
    input  logic              clk,
    input  logic              res,
    input  logic              start,
    input  logic [ADDR_W:0]   load_len,
    mcs4_rom_loader_if.master bus,
    output logic              cpu_res_n,
    output logic              busy,
    output logic              done,
    output logic              err
);
    localparam int unsigned LEN_W = ADDR_W + 1;
    localparam int unsigned SUM_W = 16;
    localparam int unsigned REL_W = (REL_DLY > 1) ? $clog2(REL_DLY) : 1;
    localparam logic [LEN_W-1:0] MAX_LEN = {1'b1, {ADDR_W{1'b0}}};

    typedef enum logic [2:0] {
        S_IDLE, S_WRITE, S_VREAD, S_VDRAIN, S_CHECK, S_RELEASE, S_FAIL
    } state_t;

    state_t             state_q, state_d;
    logic [ADDR_W-1:0]  last_q, last_d;
    logic [ADDR_W-1:0]  count_q, count_d;
    logic [SUM_W-1:0]   wsum_q, wsum_d;
    logic [SUM_W-1:0]   rsum_q, rsum_d;
    logic [REL_W-1:0]   rel_cnt_q, rel_cnt_d;
    logic               rvld_q, rvld_d;
    logic               s_ready_q, s_ready_d;
    logic               enb_q, enb_d;
    logic               re_q, re_d;
    logic               we_q, we_d;
    logic [ADDR_W-1:0]  addr_q, addr_d;
    logic [7:0]         wdata_q, wdata_d;
    logic               cpu_res_n_q, cpu_res_n_d;
    logic               busy_q, busy_d;
    logic               done_q, done_d;
    logic               err_q, err_d;
    logic               len_ok;

    assign len_ok = (load_len != '0) && (load_len <= MAX_LEN);

    // Next-state and next-output logic; strobes default low, everything else holds.
    always_comb begin
        state_d     = state_q;
        last_d      = last_q;
        count_d     = count_q;
        wsum_d      = wsum_q;
        rsum_d      = rsum_q;
        rel_cnt_d   = rel_cnt_q;
        rvld_d      = re_q;
        s_ready_d   = s_ready_q;
        enb_d       = enb_q;
        re_d        = 1'b0;
        we_d        = 1'b0;
        addr_d      = addr_q;
        wdata_d     = wdata_q;
        cpu_res_n_d = cpu_res_n_q;
        busy_d      = busy_q;
        done_d      = 1'b0;
        err_d       = err_q;

        // ROM data is valid the cycle after each read strobe.
        if (rvld_q) begin
            rsum_d = rsum_q + SUM_W'(bus.rom_init_rdata);
        end

        case (state_q)
            S_IDLE, S_FAIL: begin
                if (start) begin
                    if (len_ok) begin
                        state_d     = S_WRITE;
                        last_d      = ADDR_W'(load_len - LEN_W'(1));
                        count_d     = '0;
                        wsum_d      = '0;
                        rsum_d      = '0;
                        err_d       = 1'b0;
                        cpu_res_n_d = 1'b0;
                        enb_d       = 1'b1;
                        busy_d      = 1'b1;
                        s_ready_d   = 1'b1;
                    end else begin
                        state_d     = S_FAIL;
                        err_d       = 1'b1;
                        cpu_res_n_d = 1'b0;
                        enb_d       = 1'b0;
                        busy_d      = 1'b0;
                    end
                end
            end
            S_WRITE: begin
                if (bus.s_valid && s_ready_q) begin
                    we_d    = 1'b1;
                    addr_d  = count_q;
                    wdata_d = bus.s_data;
                    wsum_d  = wsum_q + SUM_W'(bus.s_data);
                    if (count_q == last_q) begin
                        s_ready_d = 1'b0;
                        count_d   = '0;
                        state_d   = S_VREAD;
                    end else begin
                        count_d = count_q + ADDR_W'(1);
                    end
                end
            end
            S_VREAD: begin
                re_d   = 1'b1;
                addr_d = count_q;
                if (count_q == last_q) begin
                    count_d = '0;
                    state_d = S_VDRAIN;
                end else begin
                    count_d = count_q + ADDR_W'(1);
                end
            end
            // Wait until the last strobe has retired so its data gets summed.
            S_VDRAIN: begin
                if (!re_q) begin
                    state_d = S_CHECK;
                end
            end
            S_CHECK: begin
                enb_d = 1'b0;
                if (rsum_q == wsum_q) begin
                    rel_cnt_d = '0;
                    state_d   = S_RELEASE;
                end else begin
                    err_d       = 1'b1;
                    cpu_res_n_d = 1'b0;
                    busy_d      = 1'b0;
                    state_d     = S_FAIL;
                end
            end
            S_RELEASE: begin
                if (rel_cnt_q == REL_W'(REL_DLY - 1)) begin
                    cpu_res_n_d = 1'b1;
                    done_d      = 1'b1;
                    busy_d      = 1'b0;
                    state_d     = S_IDLE;
                end else begin
                    rel_cnt_d = rel_cnt_q + REL_W'(1);
                end
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase
    end

    // State and output registers with synchronous reset.
    always_ff @(posedge clk) begin
        if (res) begin
            state_q     <= S_IDLE;
            last_q      <= '0;
            count_q     <= '0;
            wsum_q      <= '0;
            rsum_q      <= '0;
            rel_cnt_q   <= '0;
            rvld_q      <= 1'b0;
            s_ready_q   <= 1'b0;
            enb_q       <= 1'b0;
            re_q        <= 1'b0;
            we_q        <= 1'b0;
            addr_q      <= '0;
            wdata_q     <= '0;
            cpu_res_n_q <= 1'b0;
            busy_q      <= 1'b0;
            done_q      <= 1'b0;
            err_q       <= 1'b0;
        end else begin
            state_q     <= state_d;
            last_q      <= last_d;
            count_q     <= count_d;
            wsum_q      <= wsum_d;
            rsum_q      <= rsum_d;
            rel_cnt_q   <= rel_cnt_d;
            rvld_q      <= rvld_d;
            s_ready_q   <= s_ready_d;
            enb_q       <= enb_d;
            re_q        <= re_d;
            we_q        <= we_d;
            addr_q      <= addr_d;
            wdata_q     <= wdata_d;
            cpu_res_n_q <= cpu_res_n_d;
            busy_q      <= busy_d;
            done_q      <= done_d;
            err_q       <= err_d;
        end
    end

    assign bus.s_ready        = s_ready_q;
    assign bus.rom_init_enb   = enb_q;
    assign bus.rom_init_addr  = addr_q;
    assign bus.rom_init_re    = re_q;
    assign bus.rom_init_we    = we_q;
    assign bus.rom_init_wdata = wdata_q;
    assign cpu_res_n          = cpu_res_n_q;
    assign busy               = busy_q;
    assign done               = done_q;
    assign err                = err_q;
endmodule

// File: tb/tb_mcs4_rom_loader.sv
// Directed bench for mcs4_rom_loader: table of load scenarios plus hand-written
// reset, bad-length and abort sequences, with a behavioural ROM on the init port.
module tb_mcs4_rom_loader;
    localparam int unsigned ADDR_W  = 12;
    localparam int unsigned REL_DLY = 4;
    localparam int unsigned LEN_W   = ADDR_W + 1;

    logic              clk;
    logic              res;
    logic              start;
    logic [ADDR_W:0]   load_len;
    logic              cpu_res_n;
    logic              busy;
    logic              done;
    logic              err;

    mcs4_rom_loader_if #(.ADDR_W(ADDR_W)) bus ();

    mcs4_rom_loader #(.ADDR_W(ADDR_W), .REL_DLY(REL_DLY)) dut (
        .clk       (clk),
        .res       (res),
        .start     (start),
        .load_len  (load_len),
        .bus       (bus),
        .cpu_res_n (cpu_res_n),
        .busy      (busy),
        .done      (done),
        .err       (err)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // ROM model: synchronous write, read data one cycle after the strobe.
    logic [7:0] mem [0:(1 << ADDR_W) - 1];
    logic [ADDR_W-1:0] wr_addr_q [$];
    logic [7:0]        wr_data_q [$];
    int  re_cnt = 0;
    bit  corrupt = 1'b0;

    always @(posedge clk) begin
        if (bus.rom_init_we) begin
            mem[bus.rom_init_addr] <= bus.rom_init_wdata;
            wr_addr_q.push_back(bus.rom_init_addr);
            wr_data_q.push_back(bus.rom_init_wdata);
        end
        if (bus.rom_init_re) begin
            bus.rom_init_rdata <= (corrupt && bus.rom_init_addr == ADDR_W'(2)) ? 8'h57
                                                                              : mem[bus.rom_init_addr];
            re_cnt <= re_cnt + 1;
        end
    end

    // Bus rule monitor: strobes exclusive, strobes only under ENB, address stable when idle.
    int proto_err = 0;
    logic [ADDR_W-1:0] prev_addr = '0;
    always @(negedge clk) begin
        if (bus.rom_init_re && bus.rom_init_we) proto_err++;
        if ((bus.rom_init_re || bus.rom_init_we) && !bus.rom_init_enb) proto_err++;
        if (!res && !bus.rom_init_re && !bus.rom_init_we && bus.rom_init_addr != prev_addr) proto_err++;
        prev_addr = bus.rom_init_addr;
    end

    int n_tests = 0;
    int n_fail  = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
        end
    endtask

    typedef struct {
        int          len;
        logic [31:0] bytes;     // byte 0 in the top byte, used when len <= 4
        logic [7:0]  fill;      // every byte, used when len > 4
        bit          stall;     // S_VALID low on every other ready cycle
        bit          corrupt;   // ROM returns 0x57 for address 2
        bit          poke;      // extra START pulse during the write phase
        int          exp_done;  // cycles from START to DONE, 0 = no DONE
        bit          exp_err;
    } vec_t;

    vec_t vecs [7];

    function automatic logic [7:0] byte_of(input vec_t v, input int i);
        if (v.len > 4) return v.fill;
        return 8'(v.bytes >> (24 - 8 * i));
    endfunction

    task automatic run_load(input int idx);
        vec_t v;
        int wr0, re0, nbyte, wcyc, done_cyc, done_cnt, limit, bad, n;
        v        = vecs[idx];
        wr0      = wr_addr_q.size();
        re0      = re_cnt;
        nbyte    = 0;
        wcyc     = 0;
        done_cyc = 0;
        done_cnt = 0;
        limit    = 2 * v.len + 40;
        corrupt  = v.corrupt;
        @(negedge clk);
        load_len = LEN_W'(v.len);
        start    = 1'b1;
        for (int k = 1; k <= limit; k++) begin
            @(negedge clk);
            start = 1'b0;
            if (v.poke && k == 2) begin
                start    = 1'b1;
                load_len = LEN_W'(2);
            end
            if (k == 1)
                check($sformatf("v%0d_start_resp", idx), {29'd0, bus.rom_init_enb, cpu_res_n, busy}, 32'b101);
            if (done) begin
                done_cnt++;
                if (done_cyc == 0) done_cyc = k;
            end
            if (bus.s_ready && nbyte < v.len) begin
                bus.s_valid = !(v.stall && (wcyc % 2 == 1));
                bus.s_data  = byte_of(v, nbyte);
                if (bus.s_valid) nbyte++;
                wcyc++;
            end else begin
                bus.s_valid = 1'b0;
            end
        end
        check($sformatf("v%0d_done_cycle", idx), done_cyc, v.exp_done);
        check($sformatf("v%0d_done_pulses", idx), done_cnt, (v.exp_done != 0) ? 1 : 0);
        check($sformatf("v%0d_err", idx), {31'd0, err}, {31'd0, v.exp_err});
        check($sformatf("v%0d_cpu_res_n", idx), {31'd0, cpu_res_n}, {31'd0, !v.exp_err});
        check($sformatf("v%0d_idle_outs", idx), {30'd0, bus.rom_init_enb, busy}, 32'd0);
        n   = wr_addr_q.size() - wr0;
        check($sformatf("v%0d_wr_count", idx), n, v.len);
        bad = 0;
        for (int i = 0; i < n && i < v.len; i++) begin
            if (wr_addr_q[wr0 + i] != ADDR_W'(i) || wr_data_q[wr0 + i] != byte_of(v, i)) bad++;
        end
        check($sformatf("v%0d_wr_content", idx), bad, 0);
        check($sformatf("v%0d_re_count", idx), re_cnt - re0, v.len);
        corrupt = 1'b0;
    endtask

    initial begin
        int wr0, nb;
        bit seen;
        res         = 1'b1;
        start       = 1'b0;
        load_len    = '0;
        bus.s_valid = 1'b0;
        bus.s_data  = '0;

        //           len   bytes         fill  stall corrupt poke done err
        vecs[0] = '{4,    32'h12345678, 8'h00, 0, 0, 0, 16,   0};
        vecs[1] = '{4,    32'h12345678, 8'h00, 1, 0, 0, 19,   0};
        vecs[2] = '{4,    32'h12345678, 8'h00, 0, 1, 0, 0,    1};
        vecs[3] = '{4,    32'h12345678, 8'h00, 0, 0, 1, 16,   0};
        vecs[4] = '{1,    32'hA5000000, 8'h00, 0, 0, 0, 10,   0};
        vecs[5] = '{3,    32'hFFFF0100, 8'h00, 0, 0, 0, 14,   0};
        vecs[6] = '{4096, 32'h00000000, 8'hFF, 0, 0, 0, 8200, 0};

        // Reset, then ten idle cycles.
        repeat (3) @(negedge clk);
        res = 1'b0;
        repeat (10) @(negedge clk);
        check("idle_cpu_res_n", {31'd0, cpu_res_n}, 32'd0);
        check("idle_enb", {31'd0, bus.rom_init_enb}, 32'd0);
        check("idle_busy_err_done", {29'd0, busy, err, done}, 32'd0);
        check("idle_s_ready", {31'd0, bus.s_ready}, 32'd0);
        check("idle_no_we", wr_addr_q.size(), 0);
        check("idle_no_re", re_cnt, 0);

        for (int i = 0; i < 7; i++) run_load(i);

        // Zero length from IDLE with the CPU running.
        wr0 = wr_addr_q.size();
        @(negedge clk);
        load_len = '0;
        start    = 1'b1;
        @(negedge clk);
        start = 1'b0;
        check("len0_outs", {28'd0, err, cpu_res_n, bus.rom_init_enb, busy}, 32'b1000);
        repeat (3) @(negedge clk);
        check("len0_no_we", wr_addr_q.size() - wr0, 0);

        // Reset asserted during the read-back phase.
        @(negedge clk);
        load_len = LEN_W'(4);
        start    = 1'b1;
        nb       = 0;
        seen     = 1'b0;
        for (int k = 1; k <= 40; k++) begin
            @(negedge clk);
            start = 1'b0;
            if (bus.rom_init_re) begin
                seen = 1'b1;
                break;
            end
            if (bus.s_ready && nb < 4) begin
                bus.s_valid = 1'b1;
                bus.s_data  = 8'(8'h21 * (nb + 1));
                nb++;
            end else begin
                bus.s_valid = 1'b0;
            end
        end
        check("res_reached_vread", {31'd0, seen}, 32'd1);
        bus.s_valid = 1'b0;
        res = 1'b1;
        @(negedge clk);
        check("res_outputs", {3'd0, cpu_res_n, bus.rom_init_enb, bus.rom_init_re, bus.rom_init_we,
                              bus.rom_init_addr, bus.rom_init_wdata, bus.s_ready, busy, done, err}, 32'd0);
        @(negedge clk);
        res = 1'b0;
        repeat (2) @(negedge clk);

        // Oversized length.
        wr0 = wr_addr_q.size();
        load_len = LEN_W'(4097);
        start    = 1'b1;
        @(negedge clk);
        start = 1'b0;
        check("len4097_outs", {28'd0, err, cpu_res_n, bus.rom_init_enb, busy}, 32'b1000);
        repeat (3) @(negedge clk);
        check("len4097_no_we", wr_addr_q.size() - wr0, 0);

        check("bus_protocol", proto_err, 0);
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end
endmodule
